// File: rtl/tcam_lookup_arbiter_if.sv
// Bundle of lookup, response, config and TCAM-side signals for tcam_lookup_arbiter.
// Latency: none; this file holds wiring only.
// Backpressure: none; the flow-control meaning belongs to the arbiter.
interface tcam_lookup_arbiter_if #(
   parameter int NUM_REQ     = 4,
   parameter int ID_Width    = 4,
   parameter int AddressSize = 4,
   parameter int Bits        = 2 * ID_Width,
   parameter int Words       = 16
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // requester side
   logic [NUM_REQ-1:0]          lk_valid;
   logic [NUM_REQ*ID_Width-1:0] lk_id;
   logic [NUM_REQ-1:0]          lk_ready;

   // result side
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [PW-1:0]               rsp_port;
   logic                        rsp_hit;
   logic [ID_Width-1:0]         rsp_dst;
   logic [AddressSize-1:0]      rsp_addr;

   // configuration side
   logic                        cfg_valid;
   logic                        cfg_flush;
   logic [AddressSize-1:0]      cfg_addr;
   logic [Bits-1:0]             cfg_data;
   logic [Bits-1:0]             cfg_mask;
   logic                        cfg_ready;

   // TCAM macro side
   logic                        tcam_cs;
   logic                        tcam_wr;
   logic                        tcam_cmp;
   logic                        tcam_rd;
   logic                        tcam_flush;
   logic                        tcam_vbi;
   logic [Bits-1:0]             tcam_di;
   logic [Bits-1:0]             tcam_mskb;
   logic [AddressSize-1:0]      tcam_a;
   logic                        tcam_hit;
   logic [Words-1:0]            tcam_hitline;
   logic [Bits-1:0]             tcam_do;

   // arbiter view
   modport slave (
      input  lk_valid, lk_id, rsp_ready,
      input  cfg_valid, cfg_flush, cfg_addr, cfg_data, cfg_mask,
      input  tcam_hit, tcam_hitline, tcam_do,
      output lk_ready, rsp_valid, rsp_port, rsp_hit, rsp_dst, rsp_addr, cfg_ready,
      output tcam_cs, tcam_wr, tcam_cmp, tcam_rd, tcam_flush, tcam_vbi,
      output tcam_di, tcam_mskb, tcam_a
   );

   // requesters, config agent and TCAM model view
   modport master (
      output lk_valid, lk_id, rsp_ready,
      output cfg_valid, cfg_flush, cfg_addr, cfg_data, cfg_mask,
      output tcam_hit, tcam_hitline, tcam_do,
      input  lk_ready, rsp_valid, rsp_port, rsp_hit, rsp_dst, rsp_addr, cfg_ready,
      input  tcam_cs, tcam_wr, tcam_cmp, tcam_rd, tcam_flush, tcam_vbi,
      input  tcam_di, tcam_mskb, tcam_a
   );
endinterface

// File: rtl/tcam_lookup_arbiter.sv
// Round-robin arbiter serialising lookups and config ops onto one TCAM macro.
// Latency: grant to rsp_valid is 4 cycles on hit, 3 on miss; config op takes 1 cycle.
// Backpressure: rsp_ready low holds the result stable and blocks all new grants.
module tcam_lookup_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ID_Width    = 4,
   parameter int AddressSize = 4,
   parameter int Bits        = 2 * ID_Width,
   parameter int Words       = 16
) (
   input logic                  clk,
   input logic                  rst,
   tcam_lookup_arbiter_if.slave bus
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {IDLE, CFG, CMP, ENC, RD, RSP} state_t;

   state_t                 state;
   logic [PW-1:0]          rr_ptr;      // highest-priority requester for the next grant
   logic [PW-1:0]          port_q;      // requester that owns the lookup in flight
   logic                   hit_q;
   logic [AddressSize-1:0] addr_q;
   logic [ID_Width-1:0]    dst_q;
   logic                   fresh;       // first RSP cycle: tcam_do is live, not yet captured
   logic                   rsp_valid_q;
   logic                   rsp_hit_q;
   logic [AddressSize-1:0] rsp_addr_q;
   logic                   cs_q, wr_q, cmp_q, rd_q, flush_q, vbi_q;
   logic [Bits-1:0]        di_q, mskb_q;
   logic [AddressSize-1:0] a_q;

   logic [PW-1:0]          winner;
   logic                   any_req;
   logic [ID_Width-1:0]    win_id;
   logic [AddressSize-1:0] enc_addr;
   logic                   grant_en;
   logic                   unused_do_hi;

   // Round-robin pick: first valid at or above rr_ptr, else first valid below it.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!any_req && bus.lk_valid[j] && (PW'(j) >= rr_ptr)) begin
            winner  = PW'(j);
            any_req = 1'b1;
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!any_req && bus.lk_valid[j] && (PW'(j) < rr_ptr)) begin
            winner  = PW'(j);
            any_req = 1'b1;
         end
      end
      win_id = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (PW'(j) == winner) win_id = bus.lk_id[j*ID_Width +: ID_Width];
      end
   end

   // Lowest-index match line wins when several entries hit.
   always_comb begin
      enc_addr = '0;
      for (int i = Words - 1; i >= 0; i--) begin
         if (bus.tcam_hitline[i]) enc_addr = AddressSize'(i);
      end
   end

   // Grants are combinational so the requester sees ready in the cycle it is consumed.
   assign grant_en      = (state == IDLE) && !rst && !bus.cfg_valid && any_req;
   assign bus.lk_ready  = grant_en ? (NUM_REQ'(1) << winner) : '0;
   assign bus.cfg_ready = (state == IDLE) && !rst && bus.cfg_valid;

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_port  = port_q;
   assign bus.rsp_hit   = rsp_hit_q;
   assign bus.rsp_addr  = rsp_addr_q;
   // tcam_do arrives in the first RSP cycle; afterwards the captured copy keeps rsp_dst stable.
   assign bus.rsp_dst   = fresh ? bus.tcam_do[ID_Width-1:0] : dst_q;

   assign bus.tcam_cs    = cs_q;
   assign bus.tcam_wr    = wr_q;
   assign bus.tcam_cmp   = cmp_q;
   assign bus.tcam_rd    = rd_q;
   assign bus.tcam_flush = flush_q;
   assign bus.tcam_vbi   = vbi_q;
   assign bus.tcam_di    = di_q;
   assign bus.tcam_mskb  = mskb_q;
   assign bus.tcam_a     = a_q;

   assign unused_do_hi = ^bus.tcam_do[Bits-1:ID_Width];

   // Sequencer: TCAM strobes are registered on entry to the state that owns them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         port_q      <= '0;
         hit_q       <= 1'b0;
         addr_q      <= '0;
         dst_q       <= '0;
         fresh       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_addr_q  <= '0;
         cs_q        <= 1'b0;
         wr_q        <= 1'b0;
         cmp_q       <= 1'b0;
         rd_q        <= 1'b0;
         flush_q     <= 1'b0;
         vbi_q       <= 1'b0;
         di_q        <= '0;
         mskb_q      <= '0;
         a_q         <= '0;
      end else begin
         cs_q    <= 1'b0;
         wr_q    <= 1'b0;
         cmp_q   <= 1'b0;
         rd_q    <= 1'b0;
         flush_q <= 1'b0;
         vbi_q   <= 1'b0;
         di_q    <= '0;
         mskb_q  <= '0;
         a_q     <= '0;
         case (state)
            IDLE: begin
               if (bus.cfg_valid) begin
                  cs_q <= 1'b1;
                  if (bus.cfg_flush) begin
                     flush_q <= 1'b1;
                  end else begin
                     wr_q   <= 1'b1;
                     vbi_q  <= 1'b1;
                     a_q    <= bus.cfg_addr;
                     di_q   <= bus.cfg_data;
                     mskb_q <= bus.cfg_mask;
                  end
                  state <= CFG;
               end else if (any_req) begin
                  port_q <= winner;
                  rr_ptr <= (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                  cs_q   <= 1'b1;
                  cmp_q  <= 1'b1;
                  di_q   <= {win_id, {ID_Width{1'b0}}};
                  mskb_q <= {{ID_Width{1'b1}}, {ID_Width{1'b0}}};
                  state  <= CMP;
               end
            end
            CFG: state <= IDLE;
            CMP: state <= ENC;
            ENC: begin
               hit_q  <= bus.tcam_hit;
               addr_q <= enc_addr;
               if (bus.tcam_hit) begin
                  cs_q  <= 1'b1;
                  rd_q  <= 1'b1;
                  a_q   <= enc_addr;
                  state <= RD;
               end else begin
                  rsp_valid_q <= 1'b1;
                  rsp_hit_q   <= 1'b0;
                  rsp_addr_q  <= '0;
                  dst_q       <= '0;
                  fresh       <= 1'b0;
                  state       <= RSP;
               end
            end
            RD: begin
               rsp_valid_q <= 1'b1;
               rsp_hit_q   <= hit_q;
               rsp_addr_q  <= addr_q;
               fresh       <= 1'b1;
               state       <= RSP;
            end
            RSP: begin
               if (fresh) begin
                  dst_q <= bus.tcam_do[ID_Width-1:0];
                  fresh <= 1'b0;
               end
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_hit_q   <= 1'b0;
                  rsp_addr_q  <= '0;
                  dst_q       <= '0;
                  fresh       <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tcam_lookup_arbiter.sv
// Directed bench for tcam_lookup_arbiter with hand-computed expectations.
// Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
// The TCAM macro is emulated by holding hit/hitline/do at fixed values per lookup.
module tb_tcam_lookup_arbiter;
   localparam int NUM_REQ     = 4;
   localparam int ID_Width    = 4;
   localparam int AddressSize = 4;
   localparam int Bits        = 8;
   localparam int Words       = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks     = 0;
   int   failures   = 0;
   int   rd_count   = 0;
   int   ready_viol = 0;
   int   rd_before;

   always #5 clk = ~clk;

   tcam_lookup_arbiter_if #(
      .NUM_REQ(NUM_REQ), .ID_Width(ID_Width), .AddressSize(AddressSize),
      .Bits(Bits), .Words(Words)
   ) bus ();

   tcam_lookup_arbiter #(
      .NUM_REQ(NUM_REQ), .ID_Width(ID_Width), .AddressSize(AddressSize),
      .Bits(Bits), .Words(Words)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Background monitors: read strobes seen, and cycles with more than one ready bit.
   always @(negedge clk) begin
      if (bus.tcam_rd === 1'b1) rd_count++;
      if ($countones({bus.lk_ready, bus.cfg_ready}) > 1) ready_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      bus.lk_valid     = '0;
      bus.lk_id        = '0;
      bus.rsp_ready    = 1'b0;
      bus.cfg_valid    = 1'b0;
      bus.cfg_flush    = 1'b0;
      bus.cfg_addr     = '0;
      bus.cfg_data     = '0;
      bus.cfg_mask     = '0;
      bus.tcam_hit     = 1'b0;
      bus.tcam_hitline = '0;
      bus.tcam_do      = '0;

      // ---------------- reset state
      cyc();
      cyc();
      #1;
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("reset_tcam_cs",   32'(bus.tcam_cs),   32'h0);
      chk("reset_tcam_di",   32'(bus.tcam_di),   32'h0);
      chk("reset_lk_ready",  32'(bus.lk_ready),  32'h0);
      chk("reset_cfg_ready", 32'(bus.cfg_ready), 32'h0);
      rst = 1'b0;
      cyc();

      // ---------------- round robin: all four request, misses, rsp_ready held high
      bus.lk_valid  = 4'hF;
      bus.lk_id     = 16'h4321;
      bus.rsp_ready = 1'b1;
      bus.tcam_hit  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_grant", 32'(bus.lk_ready), 32'h1 << k);
         cyc();
         #1;
         chk("rr_cmp_di", 32'(bus.tcam_di), 32'((k + 1) << 4));
         chk("rr_no_grant_in_cmp", 32'(bus.lk_ready), 32'h0);
         cyc();
         cyc();
         #1;
         chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'h1);
         chk("rr_rsp_port",  32'(bus.rsp_port),  32'(k));
         cyc();
      end
      bus.lk_valid  = '0;
      bus.rsp_ready = 1'b0;

      // ---------------- config write, then hit lookup from requester 1
      bus.cfg_valid = 1'b1;
      bus.cfg_flush = 1'b0;
      bus.cfg_addr  = 4'd3;
      bus.cfg_data  = 8'h52;
      bus.cfg_mask  = 8'hF0;
      #1;
      chk("wr_cfg_ready", 32'(bus.cfg_ready), 32'h1);
      cyc();
      bus.cfg_valid = 1'b0;
      #1;
      chk("wr_cfg_ready_drop", 32'(bus.cfg_ready), 32'h0);
      chk("wr_cs",   32'(bus.tcam_cs),    32'h1);
      chk("wr_wr",   32'(bus.tcam_wr),    32'h1);
      chk("wr_vbi",  32'(bus.tcam_vbi),   32'h1);
      chk("wr_a",    32'(bus.tcam_a),     32'h3);
      chk("wr_di",   32'(bus.tcam_di),    32'h52);
      chk("wr_mskb", 32'(bus.tcam_mskb),  32'hF0);
      chk("wr_flush",32'(bus.tcam_flush), 32'h0);
      cyc();
      #1;
      chk("wr_idle_cs", 32'(bus.tcam_cs), 32'h0);
      bus.lk_valid     = 4'b0010;
      bus.lk_id        = 16'h0050;
      bus.tcam_hit     = 1'b1;
      bus.tcam_hitline = 16'h0008;
      bus.tcam_do      = 8'h52;
      #1;
      chk("hit_grant", 32'(bus.lk_ready), 32'h2);
      cyc();
      bus.lk_valid = '0;
      #1;
      chk("hit_cmp",      32'(bus.tcam_cmp),  32'h1);
      chk("hit_cmp_di",   32'(bus.tcam_di),   32'h50);
      chk("hit_cmp_mskb", 32'(bus.tcam_mskb), 32'hF0);
      cyc();
      #1;
      chk("hit_enc_strobes", 32'({bus.tcam_cs, bus.tcam_cmp, bus.tcam_rd}), 32'h0);
      cyc();
      #1;
      chk("hit_rd",        32'(bus.tcam_rd),   32'h1);
      chk("hit_rd_a",      32'(bus.tcam_a),    32'h3);
      chk("hit_rd_novalid",32'(bus.rsp_valid), 32'h0);
      cyc();
      #1;
      chk("hit_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("hit_rsp_port",  32'(bus.rsp_port),  32'h1);
      chk("hit_rsp_hit",   32'(bus.rsp_hit),   32'h1);
      chk("hit_rsp_addr",  32'(bus.rsp_addr),  32'h3);
      chk("hit_rsp_dst",   32'(bus.rsp_dst),   32'h2);
      chk("hit_rsp_rd_off",32'(bus.tcam_rd),   32'h0);
      bus.rsp_ready = 1'b1;
      cyc();
      bus.rsp_ready = 1'b0;
      #1;
      chk("hit_rsp_done", 32'(bus.rsp_valid), 32'h0);

      // ---------------- miss lookup, id 9 from requester 2
      rd_before        = rd_count;
      bus.lk_valid     = 4'b0100;
      bus.lk_id        = 16'h0900;
      bus.tcam_hit     = 1'b0;
      bus.tcam_hitline = 16'h0000;
      #1;
      chk("miss_grant", 32'(bus.lk_ready), 32'h4);
      cyc();
      bus.lk_valid = '0;
      #1;
      chk("miss_cmp_di", 32'(bus.tcam_di), 32'h90);
      cyc();
      #1;
      chk("miss_enc_novalid", 32'(bus.rsp_valid), 32'h0);
      cyc();
      #1;
      chk("miss_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("miss_rsp_hit",   32'(bus.rsp_hit),   32'h0);
      chk("miss_rsp_dst",   32'(bus.rsp_dst),   32'h0);
      chk("miss_rsp_addr",  32'(bus.rsp_addr),  32'h0);
      chk("miss_rsp_port",  32'(bus.rsp_port),  32'h2);
      chk("miss_no_rd",     32'(rd_count - rd_before), 32'h0);
      bus.rsp_ready = 1'b1;
      cyc();
      bus.rsp_ready = 1'b0;

      // ---------------- config priority over a pending lookup
      bus.cfg_valid = 1'b1;
      bus.cfg_flush = 1'b0;
      bus.cfg_addr  = 4'd5;
      bus.cfg_data  = 8'hAA;
      bus.cfg_mask  = 8'hFF;
      bus.lk_valid  = 4'b0001;
      bus.lk_id     = 16'h0007;
      #1;
      chk("prio_cfg_ready", 32'(bus.cfg_ready), 32'h1);
      chk("prio_lk_held",   32'(bus.lk_ready),  32'h0);
      cyc();
      bus.cfg_valid = 1'b0;
      #1;
      chk("prio_cfg_wr",     32'(bus.tcam_wr),  32'h1);
      chk("prio_lk_in_cfg",  32'(bus.lk_ready), 32'h0);
      cyc();
      #1;
      chk("prio_lk_grant", 32'(bus.lk_ready), 32'h1);
      cyc();
      bus.lk_valid = '0;
      cyc();
      cyc();
      #1;
      chk("prio_rsp_port", 32'(bus.rsp_port), 32'h0);
      chk("prio_rsp_hit",  32'(bus.rsp_hit),  32'h0);
      bus.rsp_ready = 1'b1;
      cyc();
      bus.rsp_ready = 1'b0;

      // ---------------- flush op
      bus.cfg_valid = 1'b1;
      bus.cfg_flush = 1'b1;
      #1;
      chk("flush_cfg_ready", 32'(bus.cfg_ready), 32'h1);
      cyc();
      bus.cfg_valid = 1'b0;
      bus.cfg_flush = 1'b0;
      #1;
      chk("flush_strobes", 32'({bus.tcam_cs, bus.tcam_flush, bus.tcam_wr, bus.tcam_vbi}), 32'hC);
      chk("flush_di",      32'(bus.tcam_di), 32'h0);
      cyc();

      // ---------------- backpressure with two matching lines (bits 4 and 5)
      bus.lk_valid     = 4'b1000;
      bus.lk_id        = 16'h5000;
      bus.tcam_hit     = 1'b1;
      bus.tcam_hitline = 16'h0030;
      bus.tcam_do      = 8'h5A;
      #1;
      chk("bp_grant", 32'(bus.lk_ready), 32'h8);
      cyc();
      bus.lk_valid = 4'b0100;
      cyc();
      cyc();
      #1;
      chk("bp_rd_a", 32'(bus.tcam_a), 32'h4);
      cyc();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_valid", 32'(bus.rsp_valid), 32'h1);
         chk("bp_port",  32'(bus.rsp_port),  32'h3);
         chk("bp_hit",   32'(bus.rsp_hit),   32'h1);
         chk("bp_addr",  32'(bus.rsp_addr),  32'h4);
         chk("bp_dst",   32'(bus.rsp_dst),   32'hA);
         chk("bp_no_grant", 32'(bus.lk_ready), 32'h0);
         cyc();
         bus.tcam_do = 8'hFF;
      end
      bus.lk_valid  = '0;
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_release_dst", 32'(bus.rsp_dst), 32'hA);
      cyc();
      bus.rsp_ready = 1'b0;
      #1;
      chk("bp_done", 32'(bus.rsp_valid), 32'h0);

      // ---------------- reset during RD
      bus.lk_valid     = 4'b0001;
      bus.lk_id        = 16'h0005;
      bus.tcam_hit     = 1'b1;
      bus.tcam_hitline = 16'h0008;
      bus.tcam_do      = 8'h52;
      #1;
      chk("rst_grant", 32'(bus.lk_ready), 32'h1);
      cyc();
      bus.lk_valid = '0;
      cyc();
      cyc();
      #1;
      chk("rst_in_rd", 32'(bus.tcam_rd), 32'h1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_strobes", 32'({bus.tcam_cs, bus.tcam_wr, bus.tcam_cmp, bus.tcam_rd,
                              bus.tcam_flush, bus.tcam_vbi}), 32'h0);
      chk("rst_tcam_bus", 32'({bus.tcam_di, bus.tcam_mskb, bus.tcam_a}), 32'h0);
      chk("rst_rsp_fields", 32'({bus.rsp_port, bus.rsp_hit, bus.rsp_dst, bus.rsp_addr}), 32'h0);
      chk("rst_readies", 32'({bus.lk_ready, bus.cfg_ready}), 32'h0);
      cyc();
      #1;
      chk("rst_stays_quiet", 32'(bus.rsp_valid), 32'h0);
      bus.lk_valid = 4'b0100;
      bus.tcam_hit = 1'b0;
      #1;
      chk("rst_next_grant", 32'(bus.lk_ready), 32'h4);
      cyc();
      bus.lk_valid = '0;
      #1;
      chk("rst_next_cmp", 32'(bus.tcam_cmp), 32'h1);
      cyc();
      cyc();
      #1;
      chk("rst_next_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("rst_next_rsp_port",  32'(bus.rsp_port),  32'h2);
      bus.rsp_ready = 1'b1;
      cyc();
      bus.rsp_ready = 1'b0;
      #1;

      chk("ready_onehot", 32'(ready_viol), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tcam_lookup_arbiter.md
TCAM_LOOKUP_ARBITER -- requirements
Module: tcam_lookup_arbiter

Interface
REQ-001 Parameters SHALL be as follows:
- NUM_REQ, default 4: number of lookup requesters.
- ID_Width, default 4: packet/destination ID width.
- AddressSize, default 4: TCAM address width.
- Bits, default 8: TCAM word width, equal to 2*ID_Width.
- Words, default 16: TCAM depth.
REQ-002 Ports SHALL be as follows:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous active-high reset.
- lk_valid, in, NUM_REQ: per-requester lookup request.
- lk_id, in, NUM_REQ*ID_Width: per-requester PacketID; slice i belongs to requester i.
- lk_ready, out, NUM_REQ: one-hot grant pulse; the request is consumed on that cycle.
- rsp_valid, out, 1: lookup result valid.
- rsp_ready, in, 1: result accepted.
- rsp_port, out, $clog2(NUM_REQ): requester index of the result.
- rsp_hit, out, 1: match found.
- rsp_dst, out, ID_Width: destination ID (DO low half); 0 on miss.
- rsp_addr, out, AddressSize: matched TCAM address; 0 on miss.
- cfg_valid, in, 1: configuration op request.
- cfg_flush, in, 1: 1 = flush op, 0 = write op.
- cfg_addr, in, AddressSize: write address.
- cfg_data, in, Bits: write data.
- cfg_mask, in, Bits: write mask.
- cfg_ready, out, 1: config op accepted this cycle.
- tcam_cs, tcam_wr, tcam_cmp, tcam_rd, tcam_flush, tcam_vbi, out, 1 each: TCAM controls.
- tcam_di, tcam_mskb, out, Bits: TCAM data and mask.
- tcam_a, out, AddressSize: TCAM address.
- tcam_hit, in, 1: TCAM hit, valid the cycle after tcam_cmp.
- tcam_hitline, in, Words: TCAM match lines, valid the cycle after tcam_cmp.
- tcam_do, in, Bits: TCAM read data, valid the cycle after tcam_rd.

Function
REQ-003 FSM states SHALL be IDLE, CFG, CMP, ENC, RD, RSP; the reset state is IDLE.
REQ-004 In IDLE, cfg_valid SHALL have strict priority over lookups: assert cfg_ready, latch the op, and go to CFG.
REQ-005 In IDLE with no cfg_valid and any lk_valid set, the block SHALL grant by round-robin:
- Search starts at the index after the last granted requester (after reset, requester 0 has highest priority).
- Pulse lk_ready for the winner only, latch its lk_id and index, and go to CMP.
REQ-006 CFG SHALL last exactly one cycle with tcam_cs=1, then return to IDLE:
- Write: tcam_wr=1, tcam_vbi=1, tcam_a=cfg_addr, tcam_di=cfg_data, tcam_mskb=cfg_mask.
- Flush: tcam_flush=1, tcam_wr=0.
REQ-007 CMP SHALL last one cycle with tcam_cs=1, tcam_cmp=1, tcam_di={latched id, ID_Width zeros}, tcam_mskb={ID_Width ones, ID_Width zeros}; next state is ENC.
REQ-008 In ENC the block SHALL register tcam_hit and, from tcam_hitline, the address of the lowest-index set bit (0 if none), then:
- go to RD on hit;
- go to RSP with rsp_hit=0, rsp_dst=0, rsp_addr=0 on miss.
REQ-009 RD SHALL last one cycle with tcam_cs=1, tcam_rd=1, tcam_a=the registered address; next state is RSP, in which rsp_dst is taken from tcam_do[ID_Width-1:0].
REQ-010 In RSP, rsp_valid SHALL be 1 and all rsp_* outputs SHALL hold stable until the cycle rsp_ready=1; the FSM then returns to IDLE.
REQ-011 Latency: grant to rsp_valid SHALL be 4 cycles on hit (CMP, ENC, RD, RSP) and 3 cycles on miss.
REQ-012 No lk_ready or cfg_ready SHALL assert outside IDLE; at most one ready bit SHALL be set per cycle.
REQ-013 Outside the active state for each signal, all tcam_* control strobes SHALL be 0, and tcam_di, tcam_mskb, tcam_a SHALL be 0.
REQ-014 A requester that drops lk_valid before its grant SHALL simply not be granted; there is no request queuing inside the block.
REQ-015 cfg_valid asserted during a lookup SHALL wait until IDLE, and SHALL be served before any pending lookup.

Reset
REQ-016 With rst=1 at a rising edge, the block SHALL return to IDLE and apply these values from the next cycle:
- All outputs 0.
- Round-robin pointer set so requester 0 has priority.
- Latched id, index, hit and address registers cleared.
REQ-017 rst asserted mid-operation (any state) SHALL abandon the operation without a response, and no tcam_* strobe SHALL assert in the cycle after reset.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Write: cfg write addr=3, data=8'h52, mask=8'hF0, then lk_valid[1]=1, lk_id=5, TCAM hitline bit 3 set, do=8'h52 -> rsp_valid 4 cycles after grant, rsp_port=1, rsp_hit=1, rsp_addr=3, rsp_dst=2.
- Miss: lookup id=9 with hitline all zeros -> rsp_valid 3 cycles after grant, rsp_hit=0, rsp_dst=0, rsp_addr=0, tcam_rd never asserted.
- Round robin: lk_valid=4'b1111 held for 4 lookups, with rsp_ready=1 -> grants in order 0,1,2,3.
- Config priority: cfg_valid and lk_valid[0] both 1 in IDLE -> cfg_ready first; CFG cycle has tcam_wr=1; lk_ready[0] is granted in the next IDLE.
- Backpressure and multiple hits: rsp_ready=0 for 5 cycles -> rsp_* stable and no new grant; hitline=16'h0030 -> rsp_addr=4.
- Reset: rst=1 during RD -> next cycle all outputs 0, no rsp_valid, state IDLE; the next lk_valid[2] alone is granted.
